// File: rtl/spi_wrapper.sv
// SPI slave front end joined to a 256 x 8 single-port RAM.
// Frames are a select bit plus 10 payload bits; read data returns on MISO.
module spi_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state, state_nxt;

    logic [9:0]           rx_data;
    logic                 rx_valid;
    logic [3:0]           rx_cnt;
    logic                 rd_addr_received;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic [2:0]           tx_cnt;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [7:0]           mem [MEM_DEPTH];

    logic in_frame;
    logic shift_en;
    logic last_bit;
    logic serialising;

    assign in_frame    = (state == WRITE) || (state == READ_ADD) ||
                         (state == READ_DATA);
    assign shift_en    = in_frame && !SS_n && (rx_cnt < 4'd10);
    assign last_bit    = shift_en && (rx_cnt == 4'd9);
    assign serialising = (state == READ_DATA) && tx_valid;

    // Slave state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; the command-select bit steers but is not kept
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!SS_n) state_nxt = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)                  state_nxt = IDLE;
                else if (!MOSI)            state_nxt = WRITE;
                else if (!rd_addr_received) state_nxt = READ_ADD;
                else                       state_nxt = READ_DATA;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload shift register, bit counter and one-cycle rx_valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_cnt   <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= last_bit;
            if (state_nxt == IDLE) begin
                rx_cnt <= '0;
            end else if (shift_en) begin
                rx_data <= {rx_data[8:0], MOSI};
                rx_cnt  <= rx_cnt + 4'd1;
            end
        end
    end

    // Tracks whether the next read-select frame carries data or address
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_addr_received <= 1'b0;
        else if (last_bit && state == READ_ADD)
            rd_addr_received <= 1'b1;
        else if (last_bit && state == READ_DATA)
            rd_addr_received <= 1'b0;
    end

    // RAM address registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (rx_valid) begin
            if (rx_data[9:8] == 2'b00) wr_addr <= rx_data[ADDR_SIZE-1:0];
            if (rx_data[9:8] == 2'b10) rd_addr <= rx_data[ADDR_SIZE-1:0];
        end
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && rx_data[9:8] == 2'b01)
            mem[wr_addr] <= rx_data[7:0];
    end

    // Read fetch; a deselect always wins so stale data never leaks out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            if (rx_valid && rx_data[9:8] == 2'b11)
                tx_data <= mem[rd_addr];
            if (SS_n)
                tx_valid <= 1'b0;
            else if (rx_valid && rx_data[9:8] == 2'b11)
                tx_valid <= 1'b1;
            else if (serialising && tx_cnt == 3'd7)
                tx_valid <= 1'b0;
        end
    end

    // Output bit index, counts 0..7 while shifting out MSB first
    always_ff @(posedge clk) begin
        if (!rst_n || SS_n || !serialising) tx_cnt <= '0;
        else                                 tx_cnt <= tx_cnt + 3'd1;
    end

    assign MISO = serialising ? tx_data[~tx_cnt] : 1'b0;

endmodule

// File: tb/tb_spi_wrapper.sv
// Self-checking bench for spi_wrapper: vector table, corner sequences
// and a randomized write/readback run against a simple memory model.
module tb_spi_wrapper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic MOSI = 1'b0;
    logic SS_n = 1'b1;
    logic MISO;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] model [256];
    bit         written [256];
    logic [7:0] wq [$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    spi_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .MOSI (MOSI),
        .SS_n (SS_n),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Select bit then nbits of payload, MSB first, driven on falling edges
    task automatic send(input bit sel, input logic [9:0] pl, input int nbits);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        MOSI = sel;
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk);
            MOSI = pl[i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        send(1'b0, {2'b00, a}, 10);
        end_frame();
        send(1'b0, {2'b01, d}, 10);
        end_frame();
        model[a] = d;
        if (!written[a]) wq.push_back(a);
        written[a] = 1'b1;
    endtask

    // Read-address then read-data frame; nb bits sampled before deselect
    task automatic rd(input logic [7:0] a, input int nb,
                      output logic [7:0] got);
        logic [7:0] dc;
        dc = 8'($urandom);
        got = '0;
        send(1'b1, {2'b10, a}, 10);
        end_frame();
        send(1'b1, {2'b11, dc}, 10);
        @(negedge clk);
        MOSI = 1'b0;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            got[7-k] = MISO;
        end
        SS_n = 1'b1;
        @(negedge clk);
        check("miso_idle_after_read", MISO, 1'b0);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] a, d, ra;

        vecs[0] = '{8'h3C, 8'hA5, 8'hA5};
        vecs[1] = '{8'hFF, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF};
        vecs[3] = '{8'h55, 8'hAA, 8'hAA};
        vecs[4] = '{8'h80, 8'h01, 8'h01};
        vecs[5] = '{8'h7F, 8'h96, 8'h96};

        // Reset held two cycles with slave selected
        rst_n = 1'b0;
        SS_n = 1'b0;
        MOSI = 1'b1;
        @(negedge clk);
        check("reset_miso_c1", MISO, 1'b0);
        @(negedge clk);
        check("reset_miso_c2", MISO, 1'b0);
        rst_n = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        check("post_reset_miso", MISO, 1'b0);

        // Known pattern: A5 at 3C, bit by bit
        wr(8'h3C, 8'hA5);
        rd(8'h3C, 8, got);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] pat;
            pat = 8'b1010_0101;
            check($sformatf("a5_bit%0d", 7 - k), got[7-k], pat[7-k]);
        end

        // Table: write everything, then read everything back
        foreach (vecs[i]) wr(vecs[i].addr, vecs[i].data);
        foreach (vecs[i]) begin
            rd(vecs[i].addr, 8, got);
            check($sformatf("vec%0d_addr%0h", i, vecs[i].addr), got,
                  vecs[i].exp);
        end

        // Back-to-back reads: flag must route the select bit to READ_ADD
        rd(8'hFF, 8, got);
        check("reread_ff", got, 8'h00);
        rd(8'h00, 8, got);
        check("reread_00", got, 8'hFF);

        // Abort a write-data frame after 5 payload bits
        wr(8'h40, 8'h11);
        send(1'b0, {2'b01, 8'hEE}, 5);
        end_frame();
        rd(8'h40, 8, got);
        check("abort_keeps_ram", got, 8'h11);
        send(1'b0, {2'b01, 8'h22}, 10);
        end_frame();
        model[8'h40] = 8'h22;
        rd(8'h40, 8, got);
        check("full_frame_after_abort", got, 8'h22);

        // Deselect mid-serialisation: 3 bits out, then MISO must be 0
        wr(8'h9A, 8'hF0);
        rd(8'h9A, 3, got);
        check("partial_read_top3", got[7:5], 3'b111);
        @(negedge clk);
        check("miso_zero_after_abort", MISO, 1'b0);
        rd(8'h9A, 8, got);
        check("read_after_ser_abort", got, 8'hF0);

        // Randomized write/readback against the model
        for (int it = 0; it < 600; it++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            wr(a, d);
            ra = wq[$urandom_range(0, wq.size() - 1)];
            rd(ra, 8, got);
            if (got !== model[ra]) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_read it=%0d addr %0h: got %0h expected %0h",
                         it, ra, got, model[ra]);
            end else begin
                n_chk++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
